id_ex_pipeline_reg: RTL and testbench
=====================================

// Module: id_ex_pipeline_reg
// PURPOSE
//  ID/EX pipeline register. Captures the decoder's control bundle and ID-stage operands each cycle and presents them to EX.
//  Detects int/float load-use hazards, asserts a one-cycle IF/ID stall and injects a bubble.
//  Applies branch flushes; holds its contents while the memory stage is busy, remembering any flush that arrives during a hold.
// PARAMETERS
//  CTRL_W   31  width of packed control bundle
//  DATA_W   32  PC/operand/immediate width
// PORTS
//  CLK            in   1       rising-edge clock
//  RESET          in   1       synchronous, active-high
//  ID_CTRL        in   CTRL_W  {ALU_SELECT[5:0],REG_WRITE_EN,FREG_WRITE_EN,DATA_MEM_WRITE[2:0],DATA_MEM_READ[3:0],BRANCH_CTRL[3:0],
//                              OPERAND1_SELECT,OPERAND2_SELECT,WRITEBACK_VALUE_SELECT[1:0],FPU_SELECT[4:0],DATA_MEM_WRITE_DATA_SELECT,REG_TYPE[1:0]} (MSB..LSB)
//  ID_PC          in   DATA_W  PC of ID instruction
//  ID_DATA1/2/3   in   DATA_W  operand values (DATA3 = float rs3)
//  ID_IMM         in   DATA_W  sign-extended immediate
//  ID_RS1/2/3     in   5       source register addresses
//  ID_RD          in   5       destination register address
//  BRANCH_FLUSH   in   1       EX branch taken; kill ID instruction
//  MEM_BUSY       in   1       downstream stall; hold all EX outputs
//  EX_CTRL        out  CTRL_W  registered control bundle
//  EX_PC, EX_DATA1/2/3, EX_IMM  out  DATA_W  registered operands
//  EX_RS1/2/3, EX_RD  out  5   registered addresses
//  STALL_OUT      out  1       combinational; freeze PC and IF/ID this cycle
// BEHAVIOUR
//  - Reset: every EX_* register = 0, so the bubble is all-zero and no write, memory or branch enable is set. flush_pending = 0. STALL_OUT = 0 while RESET.
//  - Bubble: EX_CTRL with REG_WRITE_EN, FREG_WRITE_EN, DATA_MEM_WRITE[2], DATA_MEM_READ[3] and BRANCH_CTRL[3] cleared; other fields and data are don't-care and are loaded as ID values.
//  - Load-use hazard (comb): EX_CTRL.DATA_MEM_READ[3]=1 and either of:
//     int load (EX REG_WRITE_EN=1, EX_RD!=0) matching an int source: RS1 if REG_TYPE in {00,01}; RS2 if REG_TYPE=00.
//     float load (EX FREG_WRITE_EN=1; f0 valid) matching a float source: RS2 if REG_TYPE=01; RS1 and RS2 if 10; RS1, RS2 and RS3 if 11.
//    Sources are compared whether or not the instruction uses them. Spurious stalls are accepted.
//  - Per-edge priority, highest first:
//     RESET
//     MEM_BUSY: hold all; if BRANCH_FLUSH, set flush_pending
//     BRANCH_FLUSH or flush_pending: load bubble, clear flush_pending
//     hazard: load bubble
//     otherwise: load ID values
//  - STALL_OUT = hazard & ~MEM_BUSY & ~BRANCH_FLUSH & ~flush_pending.
//  - Latency 1 cycle ID->EX. The hazard stall lasts exactly 1 cycle: after the bubble, EX is no longer a load.
//  - Back-to-back loads with dependency: each stalls independently, one bubble per dependent pair.
//  - Reset asserted mid-hold or with flush_pending: all state cleared, pending flush discarded.
// CONFIGURATION
//  ID_EX_PERF_COUNT_EN defined: adds out ports STALL_COUNT[31:0] and FLUSH_COUNT[31:0].
//   STALL_COUNT increments on each edge where a hazard bubble loads; FLUSH_COUNT on each edge where a flush bubble loads.
//   Both wrap 0xFFFFFFFF->0 and are cleared by RESET.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. RESET=1 for 2 cycles -> all EX_* = 0, STALL_OUT=0.
//  2. EX=LW x5, ID=ADD x6,x5,x1 (REG_TYPE 00) -> STALL_OUT=1 for one cycle, then a bubble in EX, then ADD in EX the next cycle.
//  3. EX=LW x0, ID rs1=x0 -> STALL_OUT=0, ID passes through. EX=FLW f0, ID=FADD rs1=f0 (10) -> STALL_OUT=1.
//  4. EX=FLW f3, ID=FMADD rs3=f3 (11) -> stall. Same EX, ID=FSW rs2=f3 (01) -> stall; FSW rs1=x3 (01) -> no stall.
//  5. MEM_BUSY=1 for 3 cycles with BRANCH_FLUSH pulsed in cycle 2 -> EX_* constant throughout; first edge after MEM_BUSY falls loads a bubble.
//  6. BRANCH_FLUSH=1 concurrent with a hazard -> STALL_OUT=0, bubble loaded. With ID_EX_PERF_COUNT_EN: FLUSH_COUNT += 1, STALL_COUNT unchanged.

Source files
------------

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: load-use hazard detection with bubble injection, branch flush,
// memory-busy hold with a deferred flush. Optional counters under ID_EX_PERF_COUNT_EN.
module id_ex_pipeline_reg #(
    parameter int unsigned CTRL_W = 31,
    parameter int unsigned DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [CTRL_W-1:0] ID_CTRL,
    input  logic [DATA_W-1:0] ID_PC,
    input  logic [DATA_W-1:0] ID_DATA1,
    input  logic [DATA_W-1:0] ID_DATA2,
    input  logic [DATA_W-1:0] ID_DATA3,
    input  logic [DATA_W-1:0] ID_IMM,
    input  logic [4:0]        ID_RS1,
    input  logic [4:0]        ID_RS2,
    input  logic [4:0]        ID_RS3,
    input  logic [4:0]        ID_RD,
    input  logic              BRANCH_FLUSH,
    input  logic              MEM_BUSY,
    output logic [CTRL_W-1:0] EX_CTRL,
    output logic [DATA_W-1:0] EX_PC,
    output logic [DATA_W-1:0] EX_DATA1,
    output logic [DATA_W-1:0] EX_DATA2,
    output logic [DATA_W-1:0] EX_DATA3,
    output logic [DATA_W-1:0] EX_IMM,
    output logic [4:0]        EX_RS1,
    output logic [4:0]        EX_RS2,
    output logic [4:0]        EX_RS3,
    output logic [4:0]        EX_RD,
`ifdef ID_EX_PERF_COUNT_EN
    output logic [31:0]       STALL_COUNT,
    output logic [31:0]       FLUSH_COUNT,
`endif
    output logic              STALL_OUT
);

    // Control bundle bit positions (bundle packs 31 bits, REG_TYPE at the LSB end).
    localparam int unsigned BIT_REG_WE     = 24;
    localparam int unsigned BIT_FREG_WE    = 23;
    localparam int unsigned BIT_MEM_WR_EN  = 22;
    localparam int unsigned BIT_MEM_RD_EN  = 19;
    localparam int unsigned BIT_BRANCH_EN  = 15;

    // Clearing these enables turns any instruction into a harmless bubble.
    localparam logic [CTRL_W-1:0] KILL_MASK =
        (CTRL_W'(1) << BIT_REG_WE)    |
        (CTRL_W'(1) << BIT_FREG_WE)   |
        (CTRL_W'(1) << BIT_MEM_WR_EN) |
        (CTRL_W'(1) << BIT_MEM_RD_EN) |
        (CTRL_W'(1) << BIT_BRANCH_EN);

    logic [CTRL_W-1:0] ex_ctrl_q;
    logic [DATA_W-1:0] ex_pc_q;
    logic [DATA_W-1:0] ex_data1_q;
    logic [DATA_W-1:0] ex_data2_q;
    logic [DATA_W-1:0] ex_data3_q;
    logic [DATA_W-1:0] ex_imm_q;
    logic [4:0]        ex_rs1_q;
    logic [4:0]        ex_rs2_q;
    logic [4:0]        ex_rs3_q;
    logic [4:0]        ex_rd_q;
    logic              flush_pending_q;

    logic [1:0] id_reg_type;
    logic       ex_is_load;
    logic       ex_int_load;
    logic       ex_float_load;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       rs3_hit;
    logic       int_hazard;
    logic       float_hazard;
    logic       hazard;
    logic       flush_now;
    logic       kill;
    logic [CTRL_W-1:0] next_ctrl;

    assign id_reg_type   = ID_CTRL[1:0];
    assign ex_is_load    = ex_ctrl_q[BIT_MEM_RD_EN];
    assign ex_int_load   = ex_ctrl_q[BIT_REG_WE] && (ex_rd_q != 5'd0);
    // f0 is a real register, so no zero-register exclusion on the float side.
    assign ex_float_load = ex_ctrl_q[BIT_FREG_WE];

    assign rs1_hit = (ID_RS1 == ex_rd_q);
    assign rs2_hit = (ID_RS2 == ex_rd_q);
    assign rs3_hit = (ID_RS3 == ex_rd_q);

    always_comb begin
        int_hazard   = 1'b0;
        float_hazard = 1'b0;
        unique case (id_reg_type)
            2'b00: int_hazard = rs1_hit || rs2_hit;
            2'b01: begin
                int_hazard   = rs1_hit;
                float_hazard = rs2_hit;
            end
            2'b10: float_hazard = rs1_hit || rs2_hit;
            2'b11: float_hazard = rs1_hit || rs2_hit || rs3_hit;
            default: ;
        endcase
    end

    assign hazard    = ex_is_load &&
                       ((ex_int_load && int_hazard) || (ex_float_load && float_hazard));
    assign flush_now = BRANCH_FLUSH || flush_pending_q;
    assign kill      = flush_now || hazard;
    assign next_ctrl = kill ? (ID_CTRL & ~KILL_MASK) : ID_CTRL;

    // A flush or a held stage already keeps the offending instruction out of EX.
    assign STALL_OUT = hazard && !MEM_BUSY && !flush_now && !RESET;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ex_ctrl_q       <= '0;
            ex_pc_q         <= '0;
            ex_data1_q      <= '0;
            ex_data2_q      <= '0;
            ex_data3_q      <= '0;
            ex_imm_q        <= '0;
            ex_rs1_q        <= '0;
            ex_rs2_q        <= '0;
            ex_rs3_q        <= '0;
            ex_rd_q         <= '0;
            flush_pending_q <= 1'b0;
        end else if (MEM_BUSY) begin
            if (BRANCH_FLUSH) begin
                flush_pending_q <= 1'b1;
            end
        end else begin
            ex_ctrl_q       <= next_ctrl;
            ex_pc_q         <= ID_PC;
            ex_data1_q      <= ID_DATA1;
            ex_data2_q      <= ID_DATA2;
            ex_data3_q      <= ID_DATA3;
            ex_imm_q        <= ID_IMM;
            ex_rs1_q        <= ID_RS1;
            ex_rs2_q        <= ID_RS2;
            ex_rs3_q        <= ID_RS3;
            ex_rd_q         <= ID_RD;
            flush_pending_q <= 1'b0;
        end
    end

    assign EX_CTRL  = ex_ctrl_q;
    assign EX_PC    = ex_pc_q;
    assign EX_DATA1 = ex_data1_q;
    assign EX_DATA2 = ex_data2_q;
    assign EX_DATA3 = ex_data3_q;
    assign EX_IMM   = ex_imm_q;
    assign EX_RS1   = ex_rs1_q;
    assign EX_RS2   = ex_rs2_q;
    assign EX_RS3   = ex_rs3_q;
    assign EX_RD    = ex_rd_q;

`ifdef ID_EX_PERF_COUNT_EN
    logic [31:0] stall_count_q;
    logic [31:0] flush_count_q;

    // A flush bubble takes precedence, so a coincident hazard is not also counted.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else if (!MEM_BUSY) begin
            if (flush_now) begin
                flush_count_q <= flush_count_q + 32'd1;
            end else if (hazard) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign STALL_COUNT = stall_count_q;
    assign FLUSH_COUNT = flush_count_q;
`endif

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Bench for id_ex_pipeline_reg: directed scenarios plus randomized traffic checked against a
// field-level behavioural model. Counter checks follow ID_EX_PERF_COUNT_EN.
module tb_id_ex_pipeline_reg;

    typedef struct packed {
        logic [5:0] alu;
        logic       rwe;
        logic       fwe;
        logic [2:0] mwr;
        logic [3:0] mrd;
        logic [3:0] br;
        logic       op1;
        logic       op2;
        logic [1:0] wb;
        logic [4:0] fpu;
        logic       wds;
        logic [1:0] rtype;
    } ctrl_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [30:0] ID_CTRL;
    logic [31:0] ID_PC, ID_DATA1, ID_DATA2, ID_DATA3, ID_IMM;
    logic [4:0]  ID_RS1, ID_RS2, ID_RS3, ID_RD;
    logic        BRANCH_FLUSH, MEM_BUSY;
    logic [30:0] EX_CTRL;
    logic [31:0] EX_PC, EX_DATA1, EX_DATA2, EX_DATA3, EX_IMM;
    logic [4:0]  EX_RS1, EX_RS2, EX_RS3, EX_RD;
    logic        STALL_OUT;
`ifdef ID_EX_PERF_COUNT_EN
    logic [31:0] STALL_COUNT, FLUSH_COUNT;
`endif

    id_ex_pipeline_reg #(.CTRL_W(31), .DATA_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .ID_CTRL(ID_CTRL), .ID_PC(ID_PC),
        .ID_DATA1(ID_DATA1), .ID_DATA2(ID_DATA2), .ID_DATA3(ID_DATA3), .ID_IMM(ID_IMM),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RS3(ID_RS3), .ID_RD(ID_RD),
        .BRANCH_FLUSH(BRANCH_FLUSH), .MEM_BUSY(MEM_BUSY),
        .EX_CTRL(EX_CTRL), .EX_PC(EX_PC), .EX_DATA1(EX_DATA1), .EX_DATA2(EX_DATA2),
        .EX_DATA3(EX_DATA3), .EX_IMM(EX_IMM), .EX_RS1(EX_RS1), .EX_RS2(EX_RS2),
        .EX_RS3(EX_RS3), .EX_RD(EX_RD),
`ifdef ID_EX_PERF_COUNT_EN
        .STALL_COUNT(STALL_COUNT), .FLUSH_COUNT(FLUSH_COUNT),
`endif
        .STALL_OUT(STALL_OUT)
    );

    always #5 CLK = ~CLK;

    int n_vectors = 0;
    int n_miscompares = 0;

    // Model of what EX must hold, kept as decoded fields.
    ctrl_t       m_ctrl;
    logic [31:0] m_pc, m_d1, m_d2, m_d3, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rs3, m_rd;
    bit          m_pending;
    int unsigned m_stall_cnt, m_flush_cnt;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic bit model_hazard();
        ctrl_t       idc;
        logic [4:0]  isrc[$];
        logic [4:0]  fsrc[$];
        bit          hit;
        idc = ctrl_t'(ID_CTRL);
        hit = 1'b0;
        if (!m_ctrl.mrd[3]) return 1'b0;
        case (idc.rtype)
            2'b00: begin isrc.push_back(ID_RS1); isrc.push_back(ID_RS2); end
            2'b01: begin isrc.push_back(ID_RS1); fsrc.push_back(ID_RS2); end
            2'b10: begin fsrc.push_back(ID_RS1); fsrc.push_back(ID_RS2); end
            default: begin
                fsrc.push_back(ID_RS1); fsrc.push_back(ID_RS2); fsrc.push_back(ID_RS3);
            end
        endcase
        if (m_ctrl.rwe && m_rd != 5'd0)
            foreach (isrc[i]) if (isrc[i] == m_rd) hit = 1'b1;
        if (m_ctrl.fwe)
            foreach (fsrc[i]) if (fsrc[i] == m_rd) hit = 1'b1;
        return hit;
    endfunction

    function automatic bit model_stall();
        return !RESET && !MEM_BUSY && !BRANCH_FLUSH && !m_pending && model_hazard();
    endfunction

    // Called just after a rising edge, with the inputs that edge sampled.
    task automatic model_edge(input bit hz);
        ctrl_t c;
        if (RESET) begin
            m_ctrl = '0; m_pc = 0; m_d1 = 0; m_d2 = 0; m_d3 = 0; m_imm = 0;
            m_rs1 = 0; m_rs2 = 0; m_rs3 = 0; m_rd = 0; m_pending = 0;
            m_stall_cnt = 0; m_flush_cnt = 0;
        end else if (MEM_BUSY) begin
            if (BRANCH_FLUSH) m_pending = 1'b1;
        end else begin
            c = ctrl_t'(ID_CTRL);
            if (BRANCH_FLUSH || m_pending) m_flush_cnt++;
            else if (hz) m_stall_cnt++;
            if (BRANCH_FLUSH || m_pending || hz) begin
                c.rwe = 0; c.fwe = 0; c.mwr[2] = 0; c.mrd[3] = 0; c.br[3] = 0;
            end
            m_ctrl = c; m_pc = ID_PC; m_d1 = ID_DATA1; m_d2 = ID_DATA2; m_d3 = ID_DATA3;
            m_imm = ID_IMM; m_rs1 = ID_RS1; m_rs2 = ID_RS2; m_rs3 = ID_RS3; m_rd = ID_RD;
            m_pending = 1'b0;
        end
    endtask

    task automatic compare_regs();
        chk("ex_ctrl", 32'(EX_CTRL), 32'(m_ctrl));
        chk("ex_pc", EX_PC, m_pc);
        chk("ex_data1", EX_DATA1, m_d1);
        chk("ex_data2", EX_DATA2, m_d2);
        chk("ex_data3", EX_DATA3, m_d3);
        chk("ex_imm", EX_IMM, m_imm);
        chk("ex_rs", {17'd0, EX_RS1, EX_RS2, EX_RS3}, {17'd0, m_rs1, m_rs2, m_rs3});
        chk("ex_rd", 32'(EX_RD), 32'(m_rd));
`ifdef ID_EX_PERF_COUNT_EN
        chk("stall_count", STALL_COUNT, m_stall_cnt);
        chk("flush_count", FLUSH_COUNT, m_flush_cnt);
`endif
    endtask

    // Inputs are set at a falling edge before calling; returns at the next falling edge.
    task automatic step();
        bit hz;
        #1;
        chk("stall_out", 32'(STALL_OUT), 32'(model_stall()));
        hz = model_hazard();
        @(posedge CLK);
        model_edge(hz);
        #1;
        compare_regs();
        @(negedge CLK);
    endtask

    function automatic ctrl_t mk(bit rwe, bit fwe, bit load, logic [1:0] rt);
        ctrl_t c;
        c = '0;
        c.alu = 6'h15; c.rwe = rwe; c.fwe = fwe; c.mrd = {load, 3'b010}; c.rtype = rt;
        return c;
    endfunction

    task automatic set_id(input ctrl_t c, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rs3, input logic [4:0] rd);
        ID_CTRL = 31'(c); ID_PC = pc; ID_RS1 = rs1; ID_RS2 = rs2; ID_RS3 = rs3; ID_RD = rd;
        ID_DATA1 = $urandom; ID_DATA2 = $urandom; ID_DATA3 = $urandom; ID_IMM = $urandom;
    endtask

    ctrl_t lw, add_c, flw, fadd, fmadd, fsw;
    int unsigned fc0, sc0;

    initial begin
        RESET = 1; BRANCH_FLUSH = 0; MEM_BUSY = 0;
        m_ctrl = '0; m_pending = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        set_id(mk(1, 0, 1, 2'b00), 32'h40, 5'd1, 5'd2, 5'd3, 5'd4);
        @(negedge CLK);
        step(); step();
        chk("rst_ex_ctrl", 32'(EX_CTRL), 32'h0);
        chk("rst_ex_pc", EX_PC, 32'h0);
        chk("rst_stall", 32'(STALL_OUT), 32'h0);

        // Int load-use: LW x5 then ADD x6,x5,x1.
        RESET = 0;
        lw = mk(1, 0, 1, 2'b00); add_c = mk(1, 0, 0, 2'b00);
        set_id(lw, 32'h100, 5'd2, 5'd0, 5'd0, 5'd5);
        step();
        set_id(add_c, 32'h104, 5'd5, 5'd1, 5'd0, 5'd6);
        #1 chk("t2_stall", 32'(STALL_OUT), 32'h1);
        chk("t2_model_stall", 32'(model_stall()), 32'h1);
        step();
        chk("t2_bubble_ctrl", 32'(EX_CTRL), 32'(add_c) & ~32'h0100_0000);
        #1 chk("t2_no_restall", 32'(STALL_OUT), 32'h0);
        step();
        chk("t2_add_ctrl", 32'(EX_CTRL), 32'(add_c));
        chk("t2_add_pc", EX_PC, 32'h104);

        // x0 load never stalls; f0 load does.
        set_id(lw, 32'h200, 5'd2, 5'd0, 5'd0, 5'd0);
        step();
        set_id(add_c, 32'h204, 5'd0, 5'd0, 5'd0, 5'd7);
        #1 chk("t3_x0_stall", 32'(STALL_OUT), 32'h0);
        step();
        chk("t3_x0_pass", 32'(EX_CTRL), 32'(add_c));
        flw = mk(0, 1, 1, 2'b01); fadd = mk(0, 1, 0, 2'b10);
        set_id(flw, 32'h208, 5'd2, 5'd0, 5'd0, 5'd0);
        step();
        set_id(fadd, 32'h20c, 5'd0, 5'd9, 5'd0, 5'd1);
        #1 chk("t3_f0_stall", 32'(STALL_OUT), 32'h1);
        step(); step();

        // Float sources by REG_TYPE.
        fmadd = mk(0, 1, 0, 2'b11); fsw = '0; fsw.mwr = 3'b110; fsw.rtype = 2'b01;
        set_id(flw, 32'h300, 5'd2, 5'd0, 5'd0, 5'd3);
        step();
        set_id(fmadd, 32'h304, 5'd7, 5'd8, 5'd3, 5'd4);
        #1 chk("t4_fmadd_stall", 32'(STALL_OUT), 32'h1);
        set_id(fsw, 32'h304, 5'd9, 5'd3, 5'd0, 5'd0);
        #1 chk("t4_fsw_rs2_stall", 32'(STALL_OUT), 32'h1);
        set_id(fsw, 32'h304, 5'd3, 5'd9, 5'd0, 5'd0);
        #1 chk("t4_fsw_rs1_stall", 32'(STALL_OUT), 32'h0);
        step();

        // Hold with a flush arriving mid-hold.
        set_id(add_c, 32'h1000, 5'd1, 5'd2, 5'd0, 5'd8);
        step();
        MEM_BUSY = 1; ID_PC = 32'h2000;
        for (int i = 0; i < 3; i++) begin
            BRANCH_FLUSH = (i == 1);
            step();
            chk("t5_hold_pc", EX_PC, 32'h1000);
            chk("t5_hold_ctrl", 32'(EX_CTRL), 32'(add_c));
        end
        MEM_BUSY = 0; BRANCH_FLUSH = 0;
        step();
        chk("t5_flush_pc", EX_PC, 32'h2000);
        chk("t5_flush_rwe", 32'(EX_CTRL[24]), 32'h0);

        // Flush concurrent with a hazard.
        set_id(lw, 32'h400, 5'd2, 5'd0, 5'd0, 5'd5);
        step();
        fc0 = m_flush_cnt; sc0 = m_stall_cnt;
        set_id(add_c, 32'h404, 5'd5, 5'd0, 5'd0, 5'd6);
        BRANCH_FLUSH = 1;
        #1 chk("t6_stall", 32'(STALL_OUT), 32'h0);
        step();
        BRANCH_FLUSH = 0;
        chk("t6_bubble_rwe", 32'(EX_CTRL[24]), 32'h0);
`ifdef ID_EX_PERF_COUNT_EN
        chk("t6_flush_delta", FLUSH_COUNT - fc0, 32'h1);
        chk("t6_stall_delta", STALL_COUNT - sc0, 32'h0);
`endif

        // Reset during a hold with a pending flush discards the flush.
        MEM_BUSY = 1; BRANCH_FLUSH = 1;
        step();
        RESET = 1; BRANCH_FLUSH = 0;
        step();
        RESET = 0; MEM_BUSY = 0;
        set_id(add_c, 32'h500, 5'd1, 5'd2, 5'd0, 5'd3);
        step();
        chk("t7_no_stale_flush", 32'(EX_CTRL), 32'(add_c));

        // Randomized traffic with small register ranges so hazards are frequent.
        for (int n = 0; n < 1500; n++) begin
            ctrl_t c;
            c = ctrl_t'(31'($urandom));
            c.mrd[3] = ($urandom_range(0, 1) == 1);
            set_id(c, $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            BRANCH_FLUSH = ($urandom_range(0, 9) == 0);
            MEM_BUSY     = ($urandom_range(0, 4) == 0);
            RESET        = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, required completion");
        $fatal(1);
    end

endmodule
